ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
- Registered successor to the combinational control decoder in the pipelined RV32 core: decodes the ID-stage instruction and registers the control bundle into the ID/EX boundary.
- Adds load-use hazard detection, branch flush, external cache-miss freeze and an optional multi-cycle MUL/DIV hold FSM.
- Sits between the IF/ID register and the EX stage, and drives the IF/PC stall.

Parameters:
- INST_W, 32, instruction width; opcode is inst[6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- ALU_CTRL_W, 4, ALU control width: {funct7[5]-or-muldiv flag, funct3}.
- EN_MULDIV, 1, 1 = decode RV32M (opcode 0110011, funct7=0000001); 0 = treat it as illegal.
- MUL_LAT, 3, EX occupancy of a MUL/DIV op in cycles (≥1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- inst_i  in  INST_W  instruction in ID
- inst_valid_i  in  1  ID holds a real instruction
- stall_ext_i  in  1  cache miss; freeze everything
- flush_i  in  1  taken branch/jump resolved in EX; kill the ID instruction
- ex_valid_o  out  1  EX slot valid
- ex_reg_we_o, ex_mem_we_o, ex_alu_imm_o, ex_jump_o, ex_jalr_o, ex_blt_o, ex_bge_o, ex_lui_o, ex_auipc_o, ex_lw_o, ex_muldiv_o  out  1 each  registered controls (all active-high)
- ex_alu_ctrl_o  out  ALU_CTRL_W  registered ALU op
- ex_rd_o  out  5  destination register
- stall_id_o  out  1  hold PC and IF/ID (combinational)
- illegal_o  out  1  sticky: an unsupported opcode was decoded

Behaviour:
- Reset (async, any time, including mid-MUL): all ex_* = 0, state = RUN, counter = 0, illegal_o = 0. stall_id_o evaluates to 0.
- Decode (alu_imm = operand B is the immediate):
  - R 0110011: reg_we, alu_ctrl = {f7[5], f3}; M-ext: muldiv, alu_ctrl = {1, f3}.
  - I-ALU 0010011: reg_we, alu_imm, alu_ctrl = {f3==101 ? f7[5] : 0, f3}.
  - LW 0000011: reg_we, alu_imm, lw.
  - SW 0100011: mem_we, alu_imm.
  - Branch 1100011: alu_ctrl = 0100; blt when f3 = 100, bge when f3 = 101; any other f3 is illegal.
  - JAL 1101111: jump, reg_we.
  - JALR 1100111: jalr, reg_we, alu_imm.
  - LUI 0110111: lui, reg_we.
  - AUIPC 0010111: auipc, reg_we.
  - Any other opcode while inst_valid_i: bubble, and illegal_o sets.
- rs-use: rs1 is used by everything except LUI/AUIPC/JAL; rs2 is used by R, SW and Branch.
- Load-use hazard: ex_valid_o & ex_lw_o & ex_rd_o≠0 & (ex_rd_o matches a used rs). Then stall_id_o = 1 and EX loads a bubble the next cycle.
- FSM RUN/MUL_WAIT:
  - A muldiv op latched into EX with MUL_LAT>1 moves to MUL_WAIT with cnt = MUL_LAT−1.
  - In MUL_WAIT: EX register holds, stall_id_o = 1, cnt decrements each cycle. When cnt reaches 1, return to RUN the next edge, so the op occupies EX for exactly MUL_LAT cycles.
  - MUL_LAT = 1 never enters MUL_WAIT.
- Priority per edge, highest first:
  1. stall_ext_i: all regs, state and cnt hold; stall_id_o = 1.
  2. flush_i: EX loads a bubble; state → RUN; cnt = 0.
  3. MUL_WAIT hold.
  4. Load-use bubble.
  5. Normal load of decoded bundle, or a bubble if !inst_valid_i.
- flush_i and stall_ext_i together: nothing changes. The requester holds flush_i until the stall clears.
- Bubble = ex_valid_o = 0 and every ex_* control = 0. ex_rd_o = 0 in a bubble.
- Latency: decode to ex_* is 1 cycle.
- ex_* are flop outputs; stall_id_o is combinational from state and ex_* regs, with no path from flush_i.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ALU op encodings;
  - FSM state encoding;
  - packed ctrl_bundle_t typedef.
- One sub-module, ctrl_decode: pure combinational inst → ctrl_bundle_t plus rs1_used, rs2_used and illegal.
- The top holds the EX register, hazard compare, FSM and counter.

Test Plan:
- Reset mid-MUL: assert rst while in MUL_WAIT → all ex_* = 0 and stall_id_o = 0 immediately; RUN after release.
- lw x5,0(x1) followed by add x6,x5,x2 → stall_id_o = 1 for one cycle, then a bubble in EX, then the add in EX with ex_alu_ctrl_o = 0000 and ex_rd_o = 6. The same sequence with rd = x0 → no stall.
- mul x3,x1,x2 with MUL_LAT = 3 → ex_muldiv_o = 1 for 3 consecutive cycles and stall_id_o = 1 for 2 cycles. With EN_MULDIV = 0 → bubble and illegal_o = 1.
- beq-type taken: flush_i while a load-use hazard is pending → EX bubble; flush wins; no extra stall cycle.
- stall_ext_i held 4 cycles during MUL_WAIT → cnt frozen; the MUL still totals 3 non-frozen EX cycles.
- Opcode table sweep (addi, srai f7[5]=1, sw, bge, jal, jalr, lui, auipc, opcode 1111111) → exact bundles per the decode table; illegal_o stays 1 until rst.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control decoder: opcodes, ALU ops,
// FSM states and the packed control bundle carried into EX.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_BRANCH = 4'b0100;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_we;
    logic       mem_we;
    logic       alu_imm;
    logic       jump;
    logic       jalr;
    logic       blt;
    logic       bge;
    logic       lui;
    logic       auipc;
    logic       lw;
    logic       muldiv;
    logic [3:0] alu_ctrl;
    logic [4:0] rd;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode_stage_decode.sv
// Combinational decode of one RV32 instruction into the EX control bundle,
// plus which source registers it reads and whether the encoding is unsupported.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INST_W    = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic [INST_W-1:0] inst,
  output ctrl_bundle_t      ctrl,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic              rs1_used,
  output logic              rs2_used,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        if (f7 == F7_MULDIV) begin
          if (EN_MULDIV) begin
            ctrl.reg_we   = 1'b1;
            ctrl.muldiv   = 1'b1;
            ctrl.alu_ctrl = {1'b1, f3};
            rs1_used      = 1'b1;
            rs2_used      = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          ctrl.reg_we   = 1'b1;
          ctrl.alu_ctrl = {f7[5], f3};
          rs1_used      = 1'b1;
          rs2_used      = 1'b1;
        end
      end
      OP_IMM: begin
        ctrl.reg_we   = 1'b1;
        ctrl.alu_imm  = 1'b1;
        ctrl.alu_ctrl = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
        rs1_used      = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_we  = 1'b1;
        ctrl.alu_imm = 1'b1;
        ctrl.lw      = 1'b1;
        rs1_used     = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_we  = 1'b1;
        ctrl.alu_imm = 1'b1;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OP_BRANCH: begin
        if (f3 == 3'b100 || f3 == 3'b101) begin
          ctrl.alu_ctrl = ALU_BRANCH;
          ctrl.blt      = (f3 == 3'b100);
          ctrl.bge      = (f3 == 3'b101);
          rs1_used      = 1'b1;
          rs2_used      = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JAL: begin
        ctrl.jump   = 1'b1;
        ctrl.reg_we = 1'b1;
      end
      OP_JALR: begin
        ctrl.jalr    = 1'b1;
        ctrl.reg_we  = 1'b1;
        ctrl.alu_imm = 1'b1;
        rs1_used     = 1'b1;
      end
      OP_LUI: begin
        ctrl.lui    = 1'b1;
        ctrl.reg_we = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.auipc  = 1'b1;
        ctrl.reg_we = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // rd is only meaningful for writers; stores/branches reuse those bits as immediate
    if (ctrl.reg_we) ctrl.rd = inst[11:7];
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID/EX control register with load-use hazard, branch flush, external freeze
// and a MUL/DIV occupancy hold; drives the IF/ID stall.
//   state       | meaning
//   ST_RUN      | EX register loads each cycle (bundle or bubble)
//   ST_MUL_WAIT | multi-cycle MUL/DIV occupies EX; EX holds, ID stalls
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int INST_W     = 32,
  parameter int ALU_CTRL_W = 4,
  parameter bit EN_MULDIV  = 1'b1,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INST_W-1:0]     inst_i,
  input  logic                  inst_valid_i,
  input  logic                  stall_ext_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  output logic                  ex_reg_we_o,
  output logic                  ex_mem_we_o,
  output logic                  ex_alu_imm_o,
  output logic                  ex_jump_o,
  output logic                  ex_jalr_o,
  output logic                  ex_blt_o,
  output logic                  ex_bge_o,
  output logic                  ex_lui_o,
  output logic                  ex_auipc_o,
  output logic                  ex_lw_o,
  output logic                  ex_muldiv_o,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl_o,
  output logic [4:0]            ex_rd_o,
  output logic                  stall_id_o,
  output logic                  illegal_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_bundle_t     dec, ex_q, ex_d;
  logic             ex_valid_q, ex_valid_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic [4:0]       rs1, rs2;
  logic             rs1_used, rs2_used, dec_illegal, load_use;

  ctrl_decode #(
    .INST_W    (INST_W),
    .EN_MULDIV (EN_MULDIV)
  ) u_decode (
    .inst     (inst_i),
    .ctrl     (dec),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .illegal  (dec_illegal)
  );

  assign load_use = inst_valid_i & ex_valid_q & ex_q.lw & (ex_q.rd != 5'd0) &
                    ((rs1_used & (ex_q.rd == rs1)) | (rs2_used & (ex_q.rd == rs2)));

  assign stall_id_o = stall_ext_i | (state_q == ST_MUL_WAIT) | load_use;

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    if (stall_ext_i) begin
      ex_d = ex_q;
    end else if (flush_i) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
      state_d    = ST_RUN;
      cnt_d      = '0;
    end else if (state_q == ST_MUL_WAIT) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d = ST_RUN;
    end else if (load_use) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
    end else if (inst_valid_i && !dec_illegal) begin
      ex_d       = dec;
      ex_valid_d = 1'b1;
      if (dec.muldiv && (MUL_LAT > 1)) begin
        state_d = ST_MUL_WAIT;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
      if (inst_valid_i) illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_reg_we_o   = ex_q.reg_we;
  assign ex_mem_we_o   = ex_q.mem_we;
  assign ex_alu_imm_o  = ex_q.alu_imm;
  assign ex_jump_o     = ex_q.jump;
  assign ex_jalr_o     = ex_q.jalr;
  assign ex_blt_o      = ex_q.blt;
  assign ex_bge_o      = ex_q.bge;
  assign ex_lui_o      = ex_q.lui;
  assign ex_auipc_o    = ex_q.auipc;
  assign ex_lw_o       = ex_q.lw;
  assign ex_muldiv_o   = ex_q.muldiv;
  assign ex_alu_ctrl_o = ex_q.alu_ctrl;
  assign ex_rd_o       = ex_q.rd;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench: each stimulus cycle pushes the expected outputs of both
// DUT instances (RV32M on / off); a negedge monitor pops and compares.
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        valid = 1'b0, valid_nm = 1'b0, ext = 1'b0, flush = 1'b0;
  logic        zero = 1'b0;

  logic        a_valid, a_reg_we, a_mem_we, a_alu_imm, a_jump, a_jalr, a_blt, a_bge;
  logic        a_lui, a_auipc, a_lw, a_muldiv, a_stall, a_illegal;
  logic [3:0]  a_alu;
  logic [4:0]  a_rd;
  logic        b_valid, b_reg_we, b_mem_we, b_alu_imm, b_jump, b_jalr, b_blt, b_bge;
  logic        b_lui, b_auipc, b_lw, b_muldiv, b_stall, b_illegal;
  logic [3:0]  b_alu;
  logic [4:0]  b_rd;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.INST_W(32), .ALU_CTRL_W(4), .EN_MULDIV(1'b1), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_valid_i(valid), .stall_ext_i(ext), .flush_i(flush),
    .ex_valid_o(a_valid), .ex_reg_we_o(a_reg_we), .ex_mem_we_o(a_mem_we), .ex_alu_imm_o(a_alu_imm),
    .ex_jump_o(a_jump), .ex_jalr_o(a_jalr), .ex_blt_o(a_blt), .ex_bge_o(a_bge), .ex_lui_o(a_lui),
    .ex_auipc_o(a_auipc), .ex_lw_o(a_lw), .ex_muldiv_o(a_muldiv), .ex_alu_ctrl_o(a_alu),
    .ex_rd_o(a_rd), .stall_id_o(a_stall), .illegal_o(a_illegal));

  ctrl_decode_stage #(.INST_W(32), .ALU_CTRL_W(4), .EN_MULDIV(1'b0), .MUL_LAT(3)) dut_nm (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_valid_i(valid_nm), .stall_ext_i(zero), .flush_i(zero),
    .ex_valid_o(b_valid), .ex_reg_we_o(b_reg_we), .ex_mem_we_o(b_mem_we), .ex_alu_imm_o(b_alu_imm),
    .ex_jump_o(b_jump), .ex_jalr_o(b_jalr), .ex_blt_o(b_blt), .ex_bge_o(b_bge), .ex_lui_o(b_lui),
    .ex_auipc_o(b_auipc), .ex_lw_o(b_lw), .ex_muldiv_o(b_muldiv), .ex_alu_ctrl_o(b_alu),
    .ex_rd_o(b_rd), .stall_id_o(b_stall), .illegal_o(b_illegal));

  wire [22:0] act_a = {a_valid, a_reg_we, a_mem_we, a_alu_imm, a_jump, a_jalr, a_blt, a_bge,
                       a_lui, a_auipc, a_lw, a_muldiv, a_alu, a_rd, a_stall, a_illegal};
  wire [22:0] act_b = {b_valid, b_reg_we, b_mem_we, b_alu_imm, b_jump, b_jalr, b_blt, b_bge,
                       b_lui, b_auipc, b_lw, b_muldiv, b_alu, b_rd, b_stall, b_illegal};

  localparam logic [10:0] C_REG = 11'h400, C_MEM = 11'h200, C_IMM = 11'h100, C_JMP = 11'h080;
  localparam logic [10:0] C_JALR = 11'h040, C_BLT = 11'h020, C_BGE = 11'h010, C_LUI = 11'h008;
  localparam logic [10:0] C_AUIPC = 11'h004, C_LW = 11'h002, C_MD = 11'h001;

  localparam logic [31:0] ADDI  = 32'h00508393;  // addi x7,x1,5
  localparam logic [31:0] SRAI  = 32'h4030D413;  // srai x8,x1,3
  localparam logic [31:0] SW    = 32'h0020A223;  // sw x2,4(x1)
  localparam logic [31:0] BGE   = 32'h0020D463;  // bge x1,x2,8
  localparam logic [31:0] JAL   = 32'h010000EF;  // jal x1,16
  localparam logic [31:0] JALR  = 32'h000280E7;  // jalr x1,0(x5)
  localparam logic [31:0] LUI   = 32'h123454B7;  // lui x9,0x12345
  localparam logic [31:0] AUIPC = 32'h00001517;  // auipc x10,1
  localparam logic [31:0] BAD   = 32'h0000007F;
  localparam logic [31:0] LW5   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] LW0   = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] ADD6  = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] ADD0  = 32'h00200333;  // add x6,x0,x2
  localparam logic [31:0] MUL   = 32'h022081B3;  // mul x3,x1,x2

  typedef struct {
    string       name;
    logic [22:0] a;
    logic [22:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [22:0] ev(input logic [10:0] c, input logic [3:0] alu,
                                     input logic [4:0] rd, input logic st, input logic il);
    return {1'b1, c, alu, rd, st, il};
  endfunction

  function automatic logic [22:0] bub(input logic st, input logic il);
    return {21'b0, st, il};
  endfunction

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %06h expected %06h", nm, act, exp);
  endtask

  task automatic step(input string nm, input logic r, input logic [31:0] ins, input logic v,
                      input logic vnm, input logic e, input logic f,
                      input logic [22:0] ea, input logic [22:0] eb);
    exp_t t;
    @(posedge clk);
    #1;
    rst = r; inst = ins; valid = v; valid_nm = vnm; ext = e; flush = f;
    t.name = nm; t.a = ea; t.b = eb;
    sb.push_back(t);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        chk({cur.name, "/m"}, act_a, cur.a);
        chk({cur.name, "/nm"}, act_b, cur.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [10:0] K_ADDI = C_REG | C_IMM;
  localparam logic [10:0] K_LW   = C_REG | C_IMM | C_LW;
  localparam logic [10:0] K_MUL  = C_REG | C_MD;

  initial begin
    // reset, then opcode sweep: EX shows the previous cycle's ID instruction
    step("reset",   1, '0,    0, 0, 0, 0, bub(0, 0), bub(0, 0));
    step("release", 0, '0,    0, 0, 0, 0, bub(0, 0), bub(0, 0));
    step("addi_id", 0, ADDI,  1, 0, 0, 0, bub(0, 0), bub(0, 0));
    step("addi",    0, SRAI,  1, 0, 0, 0, ev(K_ADDI, 4'b0000, 5'd7, 0, 0), bub(0, 0));
    step("srai",    0, SW,    1, 0, 0, 0, ev(K_ADDI, 4'b1101, 5'd8, 0, 0), bub(0, 0));
    step("sw",      0, BGE,   1, 0, 0, 0, ev(C_MEM | C_IMM, 4'b0000, 5'd0, 0, 0), bub(0, 0));
    step("bge",     0, JAL,   1, 0, 0, 0, ev(C_BGE, 4'b0100, 5'd0, 0, 0), bub(0, 0));
    step("jal",     0, JALR,  1, 0, 0, 0, ev(C_REG | C_JMP, 4'b0000, 5'd1, 0, 0), bub(0, 0));
    step("jalr",    0, LUI,   1, 0, 0, 0, ev(C_REG | C_IMM | C_JALR, 4'b0000, 5'd1, 0, 0), bub(0, 0));
    step("lui",     0, AUIPC, 1, 0, 0, 0, ev(C_REG | C_LUI, 4'b0000, 5'd9, 0, 0), bub(0, 0));
    step("auipc",   0, BAD,   1, 0, 0, 0, ev(C_REG | C_AUIPC, 4'b0000, 5'd10, 0, 0), bub(0, 0));
    step("bad_op",  0, '0,    0, 0, 0, 0, bub(0, 1), bub(0, 0));
    // load-use on x5
    step("lu_lw",   0, LW5,   1, 0, 0, 0, bub(0, 1), bub(0, 0));
    step("lu_stall",0, ADD6,  1, 0, 0, 0, ev(K_LW, 4'b0000, 5'd5, 1, 1), bub(0, 0));
    step("lu_bub",  0, ADD6,  1, 0, 0, 0, bub(0, 1), bub(0, 0));
    step("lu_add",  0, '0,    0, 0, 0, 0, ev(C_REG, 4'b0000, 5'd6, 0, 1), bub(0, 0));
    // load to x0 never stalls
    step("x0_lw",   0, LW0,   1, 0, 0, 0, bub(0, 1), bub(0, 0));
    step("x0_nost", 0, ADD0,  1, 0, 0, 0, ev(K_LW, 4'b0000, 5'd0, 0, 1), bub(0, 0));
    step("x0_add",  0, '0,    0, 0, 0, 0, ev(C_REG, 4'b0000, 5'd6, 0, 1), bub(0, 0));
    // flush during a pending load-use stall
    step("fl_lw",   0, LW5,   1, 0, 0, 0, bub(0, 1), bub(0, 0));
    step("fl_hz",   0, ADD6,  1, 0, 0, 1, ev(K_LW, 4'b0000, 5'd5, 1, 1), bub(0, 0));
    step("fl_bub",  0, ADDI,  1, 0, 0, 0, bub(0, 1), bub(0, 0));
    step("fl_tgt",  0, '0,    0, 0, 0, 0, ev(K_ADDI, 4'b0000, 5'd7, 0, 1), bub(0, 0));
    step("fl_kill", 0, ADDI,  1, 0, 0, 1, bub(0, 1), bub(0, 0));
    step("fl_kbub", 0, '0,    0, 0, 0, 0, bub(0, 1), bub(0, 0));
    // mul occupies EX for 3 cycles, stalls ID for 2
    step("mul_id",  0, MUL,   1, 0, 0, 0, bub(0, 1), bub(0, 0));
    step("mul_c1",  0, ADDI,  1, 0, 0, 0, ev(K_MUL, 4'b1000, 5'd3, 1, 1), bub(0, 0));
    step("mul_c2",  0, ADDI,  1, 0, 0, 0, ev(K_MUL, 4'b1000, 5'd3, 1, 1), bub(0, 0));
    step("mul_c3",  0, ADDI,  1, 0, 0, 0, ev(K_MUL, 4'b1000, 5'd3, 0, 1), bub(0, 0));
    step("mul_nxt", 0, '0,    0, 0, 0, 0, ev(K_ADDI, 4'b0000, 5'd7, 0, 1), bub(0, 0));
    // external freeze for 4 cycles inside MUL_WAIT
    step("mx_id",   0, MUL,   1, 0, 0, 0, bub(0, 1), bub(0, 0));
    for (int i = 0; i < 4; i++)
      step("mx_frz", 0, ADDI, 1, 0, 1, 0, ev(K_MUL, 4'b1000, 5'd3, 1, 1), bub(0, 0));
    step("mx_c1",   0, ADDI,  1, 0, 0, 0, ev(K_MUL, 4'b1000, 5'd3, 1, 1), bub(0, 0));
    step("mx_c2",   0, ADDI,  1, 0, 0, 0, ev(K_MUL, 4'b1000, 5'd3, 1, 1), bub(0, 0));
    step("mx_c3",   0, ADDI,  1, 0, 0, 0, ev(K_MUL, 4'b1000, 5'd3, 0, 1), bub(0, 0));
    step("mx_nxt",  0, '0,    0, 0, 0, 0, ev(K_ADDI, 4'b0000, 5'd7, 0, 1), bub(0, 0));
    // RV32M disabled instance: mul is a bubble and sets illegal
    step("nm_mul",  0, MUL,   0, 1, 0, 0, bub(0, 1), bub(0, 0));
    step("nm_ill",  0, '0,    0, 0, 0, 0, bub(0, 1), bub(0, 1));
    // asynchronous reset in MUL_WAIT
    step("rm_id",   0, MUL,   1, 0, 0, 0, bub(0, 1), bub(0, 1));
    step("rm_wait", 0, ADDI,  1, 0, 0, 0, ev(K_MUL, 4'b1000, 5'd3, 1, 1), bub(0, 1));
    step("rm_rst",  1, ADDI,  1, 0, 0, 0, bub(0, 0), bub(0, 0));
    step("rm_rel",  0, '0,    0, 0, 0, 0, bub(0, 0), bub(0, 0));
    step("rm_addi", 0, ADDI,  1, 0, 0, 0, bub(0, 0), bub(0, 0));
    step("rm_run",  0, '0,    0, 0, 0, 0, ev(K_ADDI, 4'b0000, 5'd7, 0, 0), bub(0, 0));
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
